// File: rtl/udp_tx_machine.sv
// rtl/udp_tx_machine.sv - single-word UDP/IPv4 frame builder feeding a byte-fetching MAC
// Latches one payload word plus destination, computes the IP header checksum, then serves bytes by address.
module udp_tx_machine #(
   parameter logic [47:0] SRC_MAC  = 48'h02_00_00_00_00_01,
   parameter logic [31:0] SRC_IP   = 32'hC0A8010A,
   parameter logic [15:0] SRC_PORT = 16'd5000,
   parameter logic [7:0]  TTL      = 8'h40
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        send_vld,
   input  logic [31:0] send_data,
   input  logic [47:0] dst_mac,
   input  logic [31:0] dst_ip,
   input  logic [15:0] dst_port,
   output logic        send_rdy,
   output logic        send_done,
   output logic        tx_vld,
   output logic [10:0] tx_count,
   input  logic [10:0] tx_addr,
   input  logic        tx_adv,
   input  logic        tx_last,
   input  logic        tx_busy,
   output logic [7:0]  tx_data
);

   typedef enum logic [2:0] {IDLE, CSUM, FOLD, REQ, SEND} state_t;

   state_t        state;
   logic [1:0]    rst_sync;
   logic [3:0]    cnt;
   logic [19:0]   acc;
   logic [19:0]   fold;
   logic [15:0]   csum;
   logic [15:0]   ip_id;
   logic [15:0]   hdr_word;
   logic [31:0]   data_q;
   logic [47:0]   mac_q;
   logic [31:0]   ip_q;
   logic [15:0]   port_q;
   logic          accept;
   logic [367:0]  frame;
   logic [5:0]    rev_idx;
   logic          unused_mac_strobes;

   // Completion is judged only by tx_busy; the byte strobes carry no state.
   assign unused_mac_strobes = tx_adv ^ tx_last;

   assign tx_count = 11'd60;
   assign send_rdy = (state == IDLE) && !tx_busy && rst_sync[1];
   assign accept   = send_vld && send_rdy;
   assign fold     = {4'h0, acc[15:0]} + {16'h0, acc[19:16]};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) rst_sync <= 2'b00;
      else         rst_sync <= {rst_sync[0], 1'b1};
   end

   always_comb begin
      hdr_word = 16'h0000;
      case (cnt)
         4'd0: hdr_word = 16'h4500;
         4'd1: hdr_word = 16'h0020;
         4'd2: hdr_word = ip_id;
         4'd4: hdr_word = {TTL, 8'h11};
         4'd6: hdr_word = SRC_IP[31:16];
         4'd7: hdr_word = SRC_IP[15:0];
         4'd8: hdr_word = ip_q[31:16];
         4'd9: hdr_word = ip_q[15:0];
         default: hdr_word = 16'h0000;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         acc       <= 20'd0;
         csum      <= 16'd0;
         ip_id     <= 16'd0;
         tx_vld    <= 1'b0;
         send_done <= 1'b0;
         data_q    <= 32'd0;
         mac_q     <= 48'd0;
         ip_q      <= 32'd0;
         port_q    <= 16'd0;
      end else begin
         send_done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  data_q <= send_data;
                  mac_q  <= dst_mac;
                  ip_q   <= dst_ip;
                  port_q <= dst_port;
                  acc    <= 20'd0;
                  cnt    <= 4'd0;
                  state  <= CSUM;
               end
            end
            CSUM: begin
               acc <= acc + {4'h0, hdr_word};
               if (cnt == 4'd9) begin
                  cnt   <= 4'd0;
                  state <= FOLD;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            FOLD: begin
               acc <= fold;
               if (cnt == 4'd1) begin
                  csum   <= ~fold[15:0];
                  cnt    <= 4'd0;
                  tx_vld <= 1'b1;
                  state  <= REQ;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            REQ: begin
               if (tx_busy) begin
                  tx_vld <= 1'b0;
                  state  <= SEND;
               end
            end
            SEND: begin
               if (!tx_busy) begin
                  send_done <= 1'b1;
                  ip_id     <= ip_id + 16'd1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Bytes 0..45 as one big-endian vector; everything beyond is zero padding.
   assign frame = {mac_q, SRC_MAC, 16'h0800, 8'h45, 8'h00, 16'h0020, ip_id,
                   16'h0000, TTL, 8'h11, csum, SRC_IP, ip_q, SRC_PORT, port_q,
                   16'h000C, 16'h0000, data_q};
   assign rev_idx = 6'd45 - tx_addr[5:0];

   always_comb begin
      tx_data = 8'h00;
      if (tx_addr < 11'd46) tx_data = frame[{rev_idx, 3'b000} +: 8];
   end

endmodule
